// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch front end between the program-counter register and decode. It keeps
// its own fetch PC, reads one 32-bit word per cycle from a combinational
// instruction memory port and buffers up to two {pc, word} entries in a small
// FIFO. The buffer head is offered to decode over a valid/ready handshake.
// Branch redirects flush the buffer and restart fetch. Fetching past the end
// of instruction memory parks the unit in HALT. A misaligned redirect target
// parks it in FAULT.
//
// Handshake: inst_valid/inst_word/inst_pc come straight from registers and
// never depend combinationally on inst_ready. An entry is consumed on a
// rising clk edge where inst_valid && inst_ready. Once inst_valid is high it
// stays high, with the same head, until that entry is consumed or a redirect
// or reset flushes the buffer. inst_ready is ignored while inst_valid is low.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   redirect     taken branch/jump: flush buffer, refetch from redirect_pc
//   redirect_pc  new fetch target (a misaligned target enters FAULT)
//   imem_addr    byte address to instruction memory (equals fetch_pc)
//   imem_rdata   instruction word at imem_addr, valid in the same cycle
//   inst_valid   buffer head is valid
//   inst_ready   decode accepts the head this cycle
//   inst_word    head instruction word (0 when empty)
//   inst_pc      head instruction PC (0 when empty)
//   fetch_pc     current fetch address register
//   halted       FSM is in HALT
//   fault        FSM is in FAULT
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int unsigned IMEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_word,
  output logic [63:0] inst_pc,
  output logic [63:0] fetch_pc,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [63:0] buf_pc_q   [2];
  logic [31:0] buf_word_q [2];

  logic pop;
  logic slot_free;
  logic in_range;
  logic fetch_try;
  logic push;

  assign inst_valid = (count_q != 2'd0);
  assign pop        = inst_valid && inst_ready;
  // A full buffer can still accept a push when the head leaves this cycle.
  assign slot_free  = (count_q < 2'd2) || pop;
  assign in_range   = (fetch_pc_q < 64'(IMEM_BYTES));
  // fetch_try is the push condition without the address-range term; when it
  // holds with an out-of-range address the unit halts instead of pushing.
  assign fetch_try  = (state_q == ST_FETCH) && slot_free && !redirect;
  assign push       = fetch_try && in_range;

  // Next-state logic: redirect overrides every other update.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect) begin
      // Flush: any pop in this cycle is discarded along with the buffer.
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      fetch_pc_d = redirect_pc;
      state_d    = (redirect_pc[1:0] == 2'b00) ? ST_FETCH : ST_FAULT;
    end else begin
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      if (push) begin
        wr_ptr_d   = ~wr_ptr_q;
        fetch_pc_d = fetch_pc_q + 64'd4;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (fetch_try && !in_range) begin
        state_d = ST_HALT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Buffer storage. Slots are only read while count_q says they hold data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_pc_q[0]   <= 64'd0;
      buf_pc_q[1]   <= 64'd0;
      buf_word_q[0] <= 32'd0;
      buf_word_q[1] <= 32'd0;
    end else if (push) begin
      buf_pc_q[wr_ptr_q]   <= fetch_pc_q;
      buf_word_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign fetch_pc  = fetch_pc_q;
  assign inst_word = inst_valid ? buf_word_q[rd_ptr_q] : 32'd0;
  assign inst_pc   = inst_valid ? buf_pc_q[rd_ptr_q]   : 64'd0;
  assign halted    = (state_q == ST_HALT);
  assign fault     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Bench for instr_fetch_unit. The instruction memory returns
// 32'h00000013 + address. A reference model tracks the expected buffer as a
// queue of {pc, word} entries, along with the fetch PC and the run mode. It
// is advanced once per clock from the inputs driven in that cycle. Directed
// sequences cover startup, backpressure, redirect and flush, misaligned
// targets, running off the end of memory and asynchronous reset. A
// randomised phase follows them.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int unsigned IMEM_BYTES = 128;
  localparam int MODE_RUN   = 0;
  localparam int MODE_HALT  = 1;
  localparam int MODE_FAULT = 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic [63:0] inst_pc;
  logic [63:0] fetch_pc;
  logic        halted;
  logic        fault;

  always #5 clk = ~clk;

  assign imem_rdata = 32'h00000013 + imem_addr[31:0];

  instr_fetch_unit #(
    .RESET_PC  (64'd0),
    .IMEM_BYTES(IMEM_BYTES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_word  (inst_word),
    .inst_pc    (inst_pc),
    .fetch_pc   (fetch_pc),
    .halted     (halted),
    .fault      (fault)
  );

  // ---------------- scoreboard / model ----------------
  logic [95:0] exp_q[$];   // expected buffer contents, {pc, word}, head first
  logic [63:0] m_pc;
  int          m_mode;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc   = 64'd0;
    m_mode = MODE_RUN;
  endtask

  task automatic check_outputs();
    logic [95:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 96'd0;
    check("inst_valid", 64'(inst_valid), 64'(exp_q.size() != 0));
    check("inst_pc",    inst_pc,         head[95:32]);
    check("inst_word",  64'(inst_word),  64'(head[31:0]));
    check("fetch_pc",   fetch_pc,        m_pc);
    check("imem_addr",  imem_addr,       m_pc);
    check("halted",     64'(halted),     64'(m_mode == MODE_HALT));
    check("fault",      64'(fault),      64'(m_mode == MODE_FAULT));
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive inputs, check the registered outputs,
  // advance the model across the next rising edge, return at the next
  // falling edge.
  task automatic step(input logic rd, input logic [63:0] rpc, input logic rdy);
    logic pop;
    redirect    = rd;
    redirect_pc = rpc;
    inst_ready  = rdy;
    check_outputs();
    pop = (exp_q.size() != 0) && rdy;
    if (rd) begin
      exp_q.delete();
      m_pc   = rpc;
      m_mode = (rpc[1:0] == 2'b00) ? MODE_RUN : MODE_FAULT;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (m_mode == MODE_RUN && exp_q.size() < 2) begin
        if (m_pc < 64'(IMEM_BYTES)) begin
          exp_q.push_back({m_pc, 32'h00000013 + m_pc[31:0]});
          m_pc = m_pc + 64'd4;
        end else begin
          m_mode = MODE_HALT;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 64'd0, rdy);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          budget;
    logic [63:0] rpc;
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 64'd0;
    inst_ready  = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    reset = 1'b0;

    // Startup stream with decode always ready.
    run(6, 1'b1);

    // Backpressure from a clean restart at 0, then release.
    step(1'b1, 64'd0, 1'b1);
    run(5, 1'b0);
    check("bp_fetch_pc_hold", fetch_pc, 64'd8);
    run(5, 1'b1);

    // Fill with 0x10/0x14, then redirect to 0x40 with decode ready.
    step(1'b1, 64'h10, 1'b0);
    run(3, 1'b0);
    step(1'b1, 64'h40, 1'b1);
    run(4, 1'b1);

    // Misaligned target, then recovery at 0x20.
    step(1'b1, 64'h22, 1'b1);
    run(4, 1'b1);
    step(1'b1, 64'h20, 1'b1);
    run(4, 1'b1);

    // Run off the end of memory, stay halted, then restart at 0.
    budget = 0;
    while (m_mode != MODE_HALT && budget < 80) begin
      step(1'b0, 64'd0, 1'b1);
      budget++;
    end
    check("halt_reached", 64'(m_mode == MODE_HALT), 64'd1);
    run(4, 1'b1);
    step(1'b1, 64'd0, 1'b1);
    run(3, 1'b1);

    // Asynchronous reset with a full buffer, checked before the next edge.
    run(4, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_fetch_pc", fetch_pc,          64'd0);
    check("async_valid",    64'(inst_valid),   64'd0);
    check("async_inst_pc",  inst_pc,           64'd0);
    model_reset();
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
    run(3, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      rpc = 64'($urandom_range(0, 36)) << 2;
      if ($urandom_range(0, 4) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      step(($urandom_range(0, 11) == 0), rpc, ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
